// File: rtl/tff_toggle_seq_if.sv
// ---------------------------------------------------------------------------
// tff_toggle_seq_if
//
// Purpose: command/status bundle for the T flip-flop toggle sequencer.
//
// Signals:
//   cmd_valid    command present (master -> slave)
//   cmd_ready    sequencer accepts a command this cycle (slave -> master)
//   cmd_mask     channels to toggle
//   cmd_count    number of toggle pulses to issue
//   cmd_gap      idle cycles between consecutive pulses
//   T            toggle enables to the T flip-flop bank
//   q_mirror     shadow of the flip-flop Q states
//   busy         high while pulsing or waiting out a gap
//   done         one-cycle completion pulse
//   pulses_left  pulses still to issue
//
// Modports: master (command source / status sink), slave (the sequencer).
// ---------------------------------------------------------------------------
interface tff_toggle_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_count;
    logic [GAP_W-1:0] cmd_gap;
    logic [WIDTH-1:0] T;
    logic [WIDTH-1:0] q_mirror;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_left;

    modport master (
        output cmd_valid, cmd_mask, cmd_count, cmd_gap,
        input  cmd_ready, T, q_mirror, busy, done, pulses_left
    );

    modport slave (
        input  cmd_valid, cmd_mask, cmd_count, cmd_gap,
        output cmd_ready, T, q_mirror, busy, done, pulses_left
    );
endinterface

// File: rtl/tff_toggle_seq.sv
// ---------------------------------------------------------------------------
// tff_toggle_seq
//
// Purpose: accepts a (mask, count, gap) command and drives the T enables of a
// bank of WIDTH T flip-flops with `count` one-cycle pulses spaced `gap` idle
// cycles apart, keeping a shadow copy of the flip-flop Q states.
//
// Ports:
//   clk    single clock, rising-edge active
//   reset  asynchronous, active-high reset
//   abort  (only with TFF_TOGGLE_SEQ_ABORT_EN) stop the running operation
//   cmd    tff_toggle_seq_if.slave: command handshake plus T / status outputs
//
// Configuration:
//   TFF_TOGGLE_SEQ_ABORT_EN  when defined, adds the abort input. Without it
//                            every accepted operation runs to completion.
// ---------------------------------------------------------------------------
module tff_toggle_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef TFF_TOGGLE_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    tff_toggle_seq_if.slave      cmd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] mask_r;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] pulses_left_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] t_w;

    logic             accept;
    logic             degenerate;
    logic             abort_hit;

    assign accept     = (state == IDLE) && cmd.cmd_valid;
    // Nothing to toggle: skip straight to DONE without a pulse.
    assign degenerate = (cmd.cmd_count == '0) || (cmd.cmd_mask == '0);

`ifdef TFF_TOGGLE_SEQ_ABORT_EN
    // abort only matters while an operation is actually running.
    assign abort_hit  = abort && ((state == PULSE) || (state == GAP));
`else
    assign abort_hit  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    state_nxt = degenerate ? DONE : PULSE;
                end
            end
            PULSE: begin
                // pulses_left still holds the count before this pulse's decrement.
                if (abort_hit || (pulses_left_r == CNT_W'(1))) begin
                    state_nxt = DONE;
                end else if (gap_r == '0) begin
                    state_nxt = PULSE;
                end else begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (abort_hit) begin
                    state_nxt = DONE;
                end else if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = PULSE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, counters and Q shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r        <= '0;
            gap_r         <= '0;
            gap_cnt       <= '0;
            pulses_left_r <= '0;
            q_r           <= '0;
        end else begin
            // A pulse in the current cycle always lands, even if aborted.
            q_r <= q_r ^ t_w;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mask_r        <= cmd.cmd_mask;
                        gap_r         <= cmd.cmd_gap;
                        pulses_left_r <= degenerate ? '0 : cmd.cmd_count;
                    end
                end
                PULSE: begin
                    pulses_left_r <= abort_hit ? '0 : (pulses_left_r - CNT_W'(1));
                    gap_cnt       <= abort_hit ? '0 : gap_r;
                end
                GAP: begin
                    if (abort_hit) begin
                        pulses_left_r <= '0;
                        gap_cnt       <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign t_w             = (state == PULSE) ? mask_r : '0;

    assign cmd.T           = t_w;
    assign cmd.q_mirror    = q_r;
    assign cmd.busy        = (state == PULSE) || (state == GAP);
    assign cmd.done        = (state == DONE);
    assign cmd.pulses_left = pulses_left_r;
    // Held low while reset is asserted so no command can be offered into reset.
    assign cmd.cmd_ready   = (state == IDLE) && !reset;

endmodule

// File: tb/tb_tff_toggle_seq.sv
// ---------------------------------------------------------------------------
// tb_tff_toggle_seq
//
// Purpose: self-checking bench for tff_toggle_seq. Directed scenarios plus a
// randomized run compared cycle by cycle against a pulse-schedule model.
// Define TFF_TOGGLE_SEQ_ABORT_EN to also exercise the abort input.
// ---------------------------------------------------------------------------
module tb_tff_toggle_seq;

    logic clk;
    logic reset;
`ifdef TFF_TOGGLE_SEQ_ABORT_EN
    logic abort;
`endif

    int n_checks;
    int n_fail;

    logic [3:0] obs_t     [64];
    logic [3:0] obs_q     [64];
    logic       obs_busy  [64];
    logic       obs_done  [64];
    logic       obs_ready [64];
    logic [7:0] obs_pl    [64];

    tff_toggle_seq_if #(.WIDTH(4), .CNT_W(8), .GAP_W(4)) bus ();

    tff_toggle_seq #(.WIDTH(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef TFF_TOGGLE_SEQ_ABORT_EN
        .abort (abort),
`endif
        .cmd   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ends at a falling edge with reset released and the sequencer idle.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
`ifdef TFF_TOGGLE_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a falling edge while idle; the next rising edge accepts.
    task automatic issue(input logic [3:0] m, input logic [7:0] c, input logic [3:0] g);
        bus.cmd_mask  = m;
        bus.cmd_count = c;
        bus.cmd_gap   = g;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Samples outputs at the falling edge of cycles first..last after accept.
    task automatic capture(input int first, input int last, input bit noise);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            obs_t[i]     = bus.T;
            obs_q[i]     = bus.q_mirror;
            obs_busy[i]  = bus.busy;
            obs_done[i]  = bus.done;
            obs_ready[i] = bus.cmd_ready;
            obs_pl[i]    = bus.pulses_left;
            if (noise) begin
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_mask  = 4'($urandom_range(0, 15));
                bus.cmd_count = 8'($urandom_range(0, 255));
                bus.cmd_gap   = 4'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_mask  = 4'h0;
        bus.cmd_count = 8'h0;
        bus.cmd_gap   = 4'h0;
`ifdef TFF_TOGGLE_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.T !== 4'b0000) begin
            n_fail++; $display("FAIL reset_T: got %b expected 0000", bus.T);
        end
        n_checks++;
        if (bus.q_mirror !== 4'b0000) begin
            n_fail++; $display("FAIL reset_q: got %b expected 0000", bus.q_mirror);
        end
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done});
        end
        n_checks++;
        if (bus.pulses_left !== 8'd0) begin
            n_fail++; $display("FAIL reset_pulses_left: got %0d expected 0", bus.pulses_left);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_after_release: got %b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_t;
        apply_reset();
        issue(4'b0011, 8'd3, 4'd2);
        capture(1, 9, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            exp_t = (i == 1 || i == 4 || i == 7) ? 4'b0011 : 4'b0000;
            n_checks++;
            if (obs_t[i] !== exp_t) begin
                n_fail++; $display("FAIL basic_T cycle %0d: got %b expected %b", i, obs_t[i], exp_t);
            end
            n_checks++;
            if (obs_done[i] !== (i == 8)) begin
                n_fail++; $display("FAIL basic_done cycle %0d: got %b expected %b", i, obs_done[i], (i == 8));
            end
            n_checks++;
            if (obs_busy[i] !== (i < 8)) begin
                n_fail++; $display("FAIL basic_busy cycle %0d: got %b expected %b", i, obs_busy[i], (i < 8));
            end
        end
        n_checks++;
        if (obs_q[9] !== 4'b0011) begin
            n_fail++; $display("FAIL basic_q: got %b expected 0011", obs_q[9]);
        end
        n_checks++;
        if ({obs_pl[1], obs_pl[2], obs_pl[5], obs_pl[8]} !== {8'd3, 8'd2, 8'd1, 8'd0}) begin
            n_fail++; $display("FAIL basic_pulses_left: got %0d %0d %0d %0d expected 3 2 1 0",
                               obs_pl[1], obs_pl[2], obs_pl[5], obs_pl[8]);
        end
        n_checks++;
        if ({obs_ready[1], obs_ready[8], obs_ready[9]} !== 3'b001) begin
            n_fail++; $display("FAIL basic_ready: got %b expected 001",
                               {obs_ready[1], obs_ready[8], obs_ready[9]});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_t;
        apply_reset();
        issue(4'b1000, 8'd4, 4'd0);
        capture(1, 6, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            exp_t = (i <= 4) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (obs_t[i] !== exp_t) begin
                n_fail++; $display("FAIL b2b_T cycle %0d: got %b expected %b", i, obs_t[i], exp_t);
            end
            n_checks++;
            if (obs_done[i] !== (i == 5)) begin
                n_fail++; $display("FAIL b2b_done cycle %0d: got %b expected %b", i, obs_done[i], (i == 5));
            end
        end
        n_checks++;
        if (obs_q[3] !== 4'b0000 || obs_q[2] !== 4'b1000 || obs_q[6] !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_q: got %b %b %b expected 1000 0000 0000", obs_q[2], obs_q[3], obs_q[6]);
        end
    endtask

    task automatic test_degenerate();
        apply_reset();
        issue(4'b0101, 8'd0, 4'd2);
        capture(1, 2, 1'b0);
        issue(4'b0000, 8'd5, 4'd1);
        capture(3, 4, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (obs_t[i] !== 4'b0000) begin
                n_fail++; $display("FAIL degen_T cycle %0d: got %b expected 0000", i, obs_t[i]);
            end
            n_checks++;
            if (obs_done[i] !== (i == 1 || i == 3)) begin
                n_fail++; $display("FAIL degen_done cycle %0d: got %b expected %b", i, obs_done[i], (i == 1 || i == 3));
            end
            n_checks++;
            if (obs_ready[i] !== (i == 2 || i == 4)) begin
                n_fail++; $display("FAIL degen_ready cycle %0d: got %b expected %b", i, obs_ready[i], (i == 2 || i == 4));
            end
            n_checks++;
            if (obs_pl[i] !== 8'd0 || obs_busy[i] !== 1'b0) begin
                n_fail++; $display("FAIL degen_pl_busy cycle %0d: got %0d/%b expected 0/0", i, obs_pl[i], obs_busy[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        issue(4'b1100, 8'd10, 4'd1);
        capture(1, 6, 1'b0);
        n_checks++;
        if (obs_q[6] !== 4'b1100 || obs_t[5] !== 4'b1100) begin
            n_fail++; $display("FAIL midrst_before: got q=%b T5=%b expected 1100 1100", obs_q[6], obs_t[5]);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.T, bus.q_mirror, bus.busy, bus.done, bus.pulses_left} !== 18'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got T=%b q=%b busy=%b done=%b pl=%0d expected all 0",
                               bus.T, bus.q_mirror, bus.busy, bus.done, bus.pulses_left);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fail++; $display("FAIL midrst_no_done: got %b expected 0", bus.done);
            end
        end
        reset = 1'b0;
        issue(4'b0001, 8'd1, 4'd0);
        capture(1, 3, 1'b0);
        n_checks++;
        if ({obs_t[1], obs_done[2], obs_q[3]} !== {4'b0001, 1'b1, 4'b0001}) begin
            n_fail++; $display("FAIL midrst_new_cmd: got T=%b done=%b q=%b expected 0001 1 0001",
                               obs_t[1], obs_done[2], obs_q[3]);
        end
    endtask

    task automatic test_busy_stability();
        apply_reset();
        issue(4'b0110, 8'd2, 4'd1);
        // Hold a different command on the bus for the whole run.
        bus.cmd_mask  = 4'b1111;
        bus.cmd_count = 8'd7;
        bus.cmd_gap   = 4'd0;
        bus.cmd_valid = 1'b1;
        capture(1, 6, 1'b0);
        bus.cmd_valid = 1'b0;
        capture(7, 15, 1'b0);
        n_checks++;
        if ({obs_t[1], obs_t[2], obs_t[3], obs_t[4]} !== {4'b0110, 4'b0000, 4'b0110, 4'b0000}) begin
            n_fail++; $display("FAIL busy_T: got %b %b %b %b expected 0110 0000 0110 0000",
                               obs_t[1], obs_t[2], obs_t[3], obs_t[4]);
        end
        n_checks++;
        if ({obs_done[3], obs_done[4], obs_pl[1], obs_pl[3]} !== {1'b0, 1'b1, 8'd2, 8'd1}) begin
            n_fail++; $display("FAIL busy_done_pl: got done3=%b done4=%b pl1=%0d pl3=%0d expected 0 1 2 1",
                               obs_done[3], obs_done[4], obs_pl[1], obs_pl[3]);
        end
        n_checks++;
        if ({obs_ready[5], obs_t[5], obs_t[6], obs_pl[6]} !== {1'b1, 4'b0000, 4'b1111, 8'd7}) begin
            n_fail++; $display("FAIL busy_next_accept: got ready5=%b T5=%b T6=%b pl6=%0d expected 1 0000 1111 7",
                               obs_ready[5], obs_t[5], obs_t[6], obs_pl[6]);
        end
        n_checks++;
        if ({obs_done[13], obs_q[15], obs_ready[15]} !== {1'b1, 4'b1111, 1'b1}) begin
            n_fail++; $display("FAIL busy_second_run: got done13=%b q=%b ready=%b expected 1 1111 1",
                               obs_done[13], obs_q[15], obs_ready[15]);
        end
    endtask

`ifdef TFF_TOGGLE_SEQ_ABORT_EN
    task automatic test_abort();
        int npulse;
        apply_reset();
        issue(4'b0101, 8'd5, 4'd3);
        capture(1, 6, 1'b0);
        abort = 1'b1;
        capture(7, 7, 1'b0);
        abort = 1'b0;
        capture(8, 9, 1'b0);
        npulse = 0;
        for (int i = 1; i <= 9; i++) if (obs_t[i] !== 4'b0000) npulse++;
        n_checks++;
        if (npulse != 2) begin
            n_fail++; $display("FAIL abort_gap_pulses: got %0d expected 2", npulse);
        end
        n_checks++;
        if ({obs_done[7], obs_pl[7], obs_ready[8], obs_q[9]} !== {1'b1, 8'd0, 1'b1, 4'b0000}) begin
            n_fail++; $display("FAIL abort_gap_end: got done=%b pl=%0d ready=%b q=%b expected 1 0 1 0000",
                               obs_done[7], obs_pl[7], obs_ready[8], obs_q[9]);
        end
        // Abort during a pulse: that pulse still lands.
        issue(4'b0011, 8'd5, 4'd0);
        abort = 1'b1;
        capture(1, 1, 1'b0);
        abort = 1'b0;
        capture(2, 3, 1'b0);
        n_checks++;
        if ({obs_t[1], obs_t[2], obs_done[2], obs_q[2], obs_pl[2]} !== {4'b0011, 4'b0000, 1'b1, 4'b0011, 8'd0}) begin
            n_fail++; $display("FAIL abort_pulse: got T1=%b T2=%b done=%b q=%b pl=%0d expected 0011 0000 1 0011 0",
                               obs_t[1], obs_t[2], obs_done[2], obs_q[2], obs_pl[2]);
        end
        // Abort held while idle is ignored.
        abort = 1'b1;
        issue(4'b1000, 8'd2, 4'd0);
        capture(1, 1, 1'b0);
        abort = 1'b0;
        capture(2, 4, 1'b0);
        n_checks++;
        if ({obs_t[1], obs_t[2], obs_done[3]} !== {4'b1000, 4'b1000, 1'b1}) begin
            n_fail++; $display("FAIL abort_idle_ignored: got T1=%b T2=%b done3=%b expected 1000 1000 1",
                               obs_t[1], obs_t[2], obs_done[3]);
        end
    endtask
`endif

    // Model: pulse k (0-based) lands in cycle 1 + k*(gap+1); done follows the
    // last pulse; a zero count or mask gives done in cycle 1 with no pulse.
    task automatic test_random();
        logic [3:0] q_m;
        logic [3:0] m;
        int         c, g, done_cyc, np_before, exp_pl;
        bit         eff, noise, is_pulse;
        logic [3:0] exp_t;
        apply_reset();
        q_m = 4'b0000;
        for (int n = 0; n < 30; n++) begin
            m     = 4'($urandom_range(0, 15));
            c     = int'($urandom_range(0, 6));
            g     = int'($urandom_range(0, 3));
            noise = 1'($urandom_range(0, 1));
            eff   = (c != 0) && (m != 4'b0000);
            done_cyc = eff ? (c - 1) * (g + 1) + 2 : 1;
            issue(m, 8'(c), 4'(g));
            capture(1, done_cyc + 1, noise);
            bus.cmd_valid = 1'b0;
            np_before = 0;
            for (int i = 1; i <= done_cyc + 1; i++) begin
                is_pulse = eff && ((i - 1) % (g + 1) == 0) && ((i - 1) / (g + 1) < c);
                exp_t    = is_pulse ? m : 4'b0000;
                exp_pl   = eff ? c - np_before : 0;
                n_checks++;
                if (obs_t[i] !== exp_t || obs_q[i] !== q_m) begin
                    n_fail++; $display("FAIL rand_T_q run %0d cycle %0d: got T=%b q=%b expected T=%b q=%b",
                                       n, i, obs_t[i], obs_q[i], exp_t, q_m);
                end
                n_checks++;
                if (obs_done[i] !== (i == done_cyc) || obs_busy[i] !== (eff && i < done_cyc)
                    || obs_ready[i] !== (i > done_cyc)) begin
                    n_fail++; $display("FAIL rand_status run %0d cycle %0d: got done=%b busy=%b ready=%b expected %b %b %b",
                                       n, i, obs_done[i], obs_busy[i], obs_ready[i],
                                       (i == done_cyc), (eff && i < done_cyc), (i > done_cyc));
                end
                n_checks++;
                if (obs_pl[i] !== 8'(exp_pl)) begin
                    n_fail++; $display("FAIL rand_pulses_left run %0d cycle %0d: got %0d expected %0d",
                                       n, i, obs_pl[i], exp_pl);
                end
                if (is_pulse) begin
                    np_before++;
                    q_m = q_m ^ m;
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_degenerate();
        test_reset_mid_run();
        test_busy_stability();
`ifdef TFF_TOGGLE_SEQ_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
